// File: rtl/bomb_pkg.sv
// bomb_pkg: definitions shared by the bomb blast sequencer and its frame counter.
//   - state_t and the sequencer state constants (IDLE, ARMED, PRIME, BLAST, COOLDOWN)
//   - blast pattern indices driven on blast_num
//   - TILE_BITS: log2 of the tile size that bomb positions snap to
//   - mod3_3b(): folds a 3-bit random value onto the three blast patterns

package bomb_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle     = 3'd0;
   localparam state_t StArmed    = 3'd1;
   localparam state_t StPrime    = 3'd2;
   localparam state_t StBlast    = 3'd3;
   localparam state_t StCooldown = 3'd4;

   localparam logic [2:0] BLAST_REGULAR    = 3'd0;
   localparam logic [2:0] BLAST_VERTICAL   = 3'd1;
   localparam logic [2:0] BLAST_HORIZONTAL = 3'd2;
   localparam int unsigned NUM_BLAST_PATTERNS = 3;

   localparam int unsigned TILE_BITS = 5;

   // 0..7 -> 0,1,2,0,1,2,0,1
   function automatic logic [2:0] mod3_3b(input logic [2:0] v);
      logic [2:0] r;
      unique case (v)
         3'd0, 3'd3, 3'd6: r = BLAST_REGULAR;
         3'd1, 3'd4, 3'd7: r = BLAST_VERTICAL;
         default:          r = BLAST_HORIZONTAL;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// frame_tick_counter: clearable 8-bit frame counter.
// Ports:
//   clk_i    - system clock
//   rst_i    - synchronous active-high reset
//   clear_i  - force the count to 0 on the next edge (wins over tick_i)
//   tick_i   - one-cycle frame pulse; advances the count
//   last_i   - terminal count value (limit - 1)
//   cnt_d_o  - next-state count, so callers can register count-derived outputs
//   tc_o     - tick_i arriving while the count sits at last_i

module frame_tick_counter (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clear_i,
   input  logic       tick_i,
   input  logic [7:0] last_i,
   output logic [7:0] cnt_d_o,
   output logic       tc_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (tick_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_d_o = cnt_d;
   assign tc_o    = tick_i && (cnt_q == last_i);

endmodule

// File: rtl/bomb_blast_sequencer.sv
// bomb_blast_sequencer: owns one bomb from placement to explosion and drives the
// blast/blast_num pair sampled by the blast-bitmap drawer.
// Ports:
//   clk          - system clock
//   resetN       - synchronous reset, active-high
//   startOfFrame - one-cycle pulse per video frame
//   place_bomb   - request to place a bomb (honoured in IDLE only)
//   playerX/Y    - player top-left position in pixels
//   random_num   - free-running random value, picks the blast pattern
//   chain_hit    - another blast covers this bomb; detonate early
//   bomb_active  - fuse running (ARMED or PRIME)
//   bombX/Y      - latched, tile-aligned bomb position
//   fuse_blink   - sprite blink flag, fast near the end of the fuse
//   blast        - explosion in progress
//   blast_num    - blast pattern index 0..2, stable before blast rises
//   busy         - sequencer not idle
//   done         - one-cycle pulse as the blast ends
// Every output is a flop; next values are derived from the next state.

module bomb_blast_sequencer
   import bomb_pkg::*;
#(
   parameter int unsigned FUSE_FRAMES       = 180,
   parameter int unsigned BLAST_FRAMES      = 30,
   parameter int unsigned COOLDOWN_FRAMES   = 15,
   parameter int unsigned FAST_BLINK_FRAMES = 32
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        place_bomb,
   input  logic [10:0] playerX,
   input  logic [10:0] playerY,
   input  logic [2:0]  random_num,
   input  logic        chain_hit,
   output logic        bomb_active,
   output logic [10:0] bombX,
   output logic [10:0] bombY,
   output logic        fuse_blink,
   output logic        blast,
   output logic [2:0]  blast_num,
   output logic        busy,
   output logic        done
);

   if ((FUSE_FRAMES == 0) || (FUSE_FRAMES > 255) ||
       (BLAST_FRAMES == 0) || (BLAST_FRAMES > 255) ||
       (COOLDOWN_FRAMES == 0) || (COOLDOWN_FRAMES > 255) ||
       (FAST_BLINK_FRAMES > 255)) begin : g_bad_frames
      $error("bomb_blast_sequencer: *_FRAMES parameters must lie in 1..255");
   end

   localparam logic [7:0]  FuseLast  = 8'(FUSE_FRAMES - 1);
   localparam logic [7:0]  BlastLast = 8'(BLAST_FRAMES - 1);
   localparam logic [7:0]  CoolLast  = 8'(COOLDOWN_FRAMES - 1);
   localparam logic [10:0] TileMask  = 11'((1 << TILE_BITS) - 1);

   state_t      state_q, state_d;
   logic [7:0]  last;
   logic [7:0]  cnt_d;
   logic        frame_tc;
   logic [8:0]  remaining;

   logic        bomb_active_q, bomb_active_d;
   logic [10:0] bomb_x_q, bomb_x_d;
   logic [10:0] bomb_y_q, bomb_y_d;
   logic        fuse_blink_q, fuse_blink_d;
   logic        blast_q, blast_d;
   logic [2:0]  blast_num_q, blast_num_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   always_comb begin
      last = 8'hff;
      unique case (state_q)
         StArmed:    last = FuseLast;
         StBlast:    last = BlastLast;
         StCooldown: last = CoolLast;
         default:    last = 8'hff;
      endcase
   end

   // The count restarts from 0 every time the state changes.
   frame_tick_counter u_frame_cnt (
      .clk_i   (clk),
      .rst_i   (resetN),
      .clear_i (state_d != state_q),
      .tick_i  (startOfFrame),
      .last_i  (last),
      .cnt_d_o (cnt_d),
      .tc_o    (frame_tc)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (place_bomb) state_d = StArmed;
         // chain_hit and fuse expiry in the same cycle still give one PRIME
         StArmed:    if (chain_hit || frame_tc) state_d = StPrime;
         StPrime:    state_d = StBlast;
         StBlast:    if (frame_tc) state_d = StCooldown;
         StCooldown: if (frame_tc) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   assign remaining = 9'(FUSE_FRAMES) - {1'b0, cnt_d};

   always_comb begin
      bomb_active_d = (state_d == StArmed) || (state_d == StPrime);
      blast_d       = (state_d == StBlast);
      busy_d        = (state_d != StIdle);
      done_d        = (state_q == StBlast) && (state_d == StCooldown);

      bomb_x_d = bomb_x_q;
      bomb_y_d = bomb_y_q;
      if ((state_q == StIdle) && place_bomb) begin
         bomb_x_d = playerX & ~TileMask;
         bomb_y_d = playerY & ~TileMask;
      end

      // Captured on PRIME entry so the drawer sees it a full cycle before blast.
      blast_num_d = blast_num_q;
      if ((state_q == StArmed) && (state_d == StPrime)) begin
         blast_num_d = mod3_3b(random_num);
      end

      fuse_blink_d = 1'b0;
      if (state_d == StArmed) begin
         fuse_blink_d = (remaining < 9'(FAST_BLINK_FRAMES)) ? cnt_d[1] : cnt_d[3];
      end
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         state_q       <= StIdle;
         bomb_active_q <= 1'b0;
         bomb_x_q      <= '0;
         bomb_y_q      <= '0;
         fuse_blink_q  <= 1'b0;
         blast_q       <= 1'b0;
         blast_num_q   <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         bomb_active_q <= bomb_active_d;
         bomb_x_q      <= bomb_x_d;
         bomb_y_q      <= bomb_y_d;
         fuse_blink_q  <= fuse_blink_d;
         blast_q       <= blast_d;
         blast_num_q   <= blast_num_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bomb_active = bomb_active_q;
   assign bombX       = bomb_x_q;
   assign bombY       = bomb_y_q;
   assign fuse_blink  = fuse_blink_q;
   assign blast       = blast_q;
   assign blast_num   = blast_num_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_bomb_blast_sequencer.sv
// Scoreboard bench for bomb_blast_sequencer. The stimulus process places bombs and
// pushes the expected episode (position, pattern, fuse length) into a queue; the
// monitor measures each episode from the outputs at negedges and compares.

module tb_bomb_blast_sequencer;

   localparam int FUSE  = 180;
   localparam int BLSTF = 30;
   localparam int COOLF = 15;
   localparam int FASTF = 32;

   logic        clk = 1'b0;
   logic        resetN, startOfFrame, place_bomb, chain_hit;
   logic [10:0] playerX, playerY;
   logic [2:0]  random_num;
   logic        bomb_active, fuse_blink, blast, busy, done;
   logic [10:0] bombX, bombY;
   logic [2:0]  blast_num;

   always #5 clk = ~clk;

   bomb_blast_sequencer dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .place_bomb   (place_bomb),
      .playerX      (playerX),
      .playerY      (playerY),
      .random_num   (random_num),
      .chain_hit    (chain_hit),
      .bomb_active  (bomb_active),
      .bombX        (bombX),
      .bombY        (bombY),
      .fuse_blink   (fuse_blink),
      .blast        (blast),
      .blast_num    (blast_num),
      .busy         (busy),
      .done         (done)
   );

   typedef struct {
      int x;
      int y;
      int num;
      int fuse;
      int place_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   sof_total = 0;
   int   gap_left = 3;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL timeout %s: condition not reached (cycle %0d)", name, cyc);
   endtask

   // Advance one clock; inputs change 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      place_bomb = 1'b0;
      chain_hit  = 1'b0;
      if (gap_left <= 1) begin
         startOfFrame = 1'b1;
         sof_total++;
         gap_left = $urandom_range(2, 5);
      end else begin
         startOfFrame = 1'b0;
         gap_left--;
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return busy;
         default: return blast;
      endcase
   endfunction

   task automatic wait_sig(input string name, input int which, input logic lvl,
                           input int budget);
      int n = 0;
      while (sig(which) !== lvl) begin
         if (n == budget) begin
            timeout(name);
            return;
         end
         step();
         n++;
      end
   endtask

   // chain_at: 0 = natural fuse, 1..FUSE-1 = chain_hit after that many frames,
   // FUSE = chain_hit together with the expiring frame.
   // abort_at >= 0: reset once that many BLAST frames have elapsed.
   task automatic run_episode(input int x, input int y, input int rn, input int chain_at,
                              input int abort_at);
      exp_t e;
      int   base, issued, n, bbase;
      bit   chained = 0;
      playerX    = 11'(x);
      playerY    = 11'(y);
      random_num = 3'(rn);
      place_bomb = 1'b1;
      e.x = (x / 32) * 32;
      e.y = (y / 32) * 32;
      e.num = rn % 3;
      e.fuse = (chain_at == 0) ? FUSE : chain_at;
      e.place_cyc = cyc;
      exp_q.push_back(e);
      base = sof_total;
      step();
      // ignored request while armed
      place_bomb = 1'b1;
      playerX = 11'($urandom_range(0, 2047));
      playerY = 11'($urandom_range(0, 2047));
      for (n = 0; n < 4000 && blast !== 1'b1; n++) begin
         issued = sof_total - base;
         if (!chained && chain_at != 0 && issued == chain_at &&
             startOfFrame == (chain_at == FUSE)) begin
            chain_hit = 1'b1;
            chained = 1;
         end
         step();
      end
      if (blast !== 1'b1) begin
         timeout("blast_rise");
         return;
      end
      // first BLAST cycle: disturb the pattern source and try to place again
      random_num = 3'($urandom_range(0, 7));
      place_bomb = 1'b1;
      playerX = 11'($urandom_range(0, 2047));
      bbase = sof_total - int'(startOfFrame);
      if (abort_at >= 0) begin
         for (n = 0; n < 1000; n++) begin
            if (sof_total - bbase == abort_at && !startOfFrame) break;
            step();
         end
         resetN = 1'b1;
         step();
         resetN = 1'b0;
         return;
      end
      wait_sig("blast_fall", 1, 1'b0, 1000);
      place_bomb = 1'b1;
      playerY = 11'($urandom_range(0, 2047));
      wait_sig("busy_fall", 0, 1'b0, 500);
   endtask

   // ---------------------------------------------------------------- monitor
   logic rst_prev = 1'b1;
   logic prev_ba = 1'b0, prev_blast = 1'b0, prev_blink = 1'b0, prev_sof = 1'b0;
   bit   in_ep = 0, in_cool = 0;
   exp_t cur;
   int   k, blink_err, blast_err, blast_frames, cool_frames, cool_err, pos_err;
   int   eps_done = 0;
   int   spurious_done = 0;

   always @(negedge clk) begin
      int exp_blink;
      if (rst_prev) begin
         check("reset_outputs", {bomb_active, bombX, bombY, fuse_blink, blast, blast_num,
                                 busy, done}, 0);
         in_ep = 0;
         in_cool = 0;
      end else begin
         if (done === 1'b1 && !(prev_blast && !blast)) spurious_done++;
         if (bomb_active && !prev_ba) begin
            if (exp_q.size() == 0) begin
               check("unexpected_bomb", bomb_active, 0);
            end else begin
               cur = exp_q.pop_front();
               in_ep = 1;
               k = 0; blink_err = 0; blast_err = 0; pos_err = 0; cool_err = 0;
               check("place_latency", cyc - cur.place_cyc, 1);
               check("bombX", bombX, cur.x);
               check("bombY", bombY, cur.y);
            end
         end
         if (in_ep) begin
            if (prev_ba) begin
               if (blast && !prev_blast) begin
                  // previous cycle was PRIME
                  if (prev_blink) blink_err++;
                  check("fuse_frames", k, cur.fuse);
                  check("blast_num", blast_num, cur.num);
                  check("fuse_blink", blink_err, 0);
                  blast_frames = 0;
               end else if (bomb_active) begin
                  // previous cycle was ARMED with k frames elapsed
                  exp_blink = (FUSE - k < FASTF) ? (k / 2) % 2 : (k / 8) % 2;
                  if (int'(prev_blink) != exp_blink) blink_err++;
                  k += int'(prev_sof);
               end else begin
                  check("bomb_to_blast", blast, 1);
               end
            end
            if (blast) begin
               if (blast_num != 3'(cur.num) || bomb_active || fuse_blink) blast_err++;
               blast_frames += int'(startOfFrame);
            end
            if (prev_blast && !blast) begin
               check("blast_frames", blast_frames, BLSTF);
               check("done_pulse", done, 1);
               check("blast_hold", blast_err, 0);
               in_cool = 1;
               cool_frames = 0;
            end
            if (busy && (bombX != 11'(cur.x) || bombY != 11'(cur.y))) pos_err++;
            if (in_cool) begin
               if (busy) begin
                  cool_frames += int'(startOfFrame);
                  if (blast || bomb_active || fuse_blink) cool_err++;
               end else begin
                  check("cooldown_frames", cool_frames, COOLF);
                  check("position_hold", pos_err, 0);
                  check("cooldown_quiet", cool_err, 0);
                  in_cool = 0;
                  in_ep = 0;
                  eps_done++;
               end
            end
         end
      end
      rst_prev   = resetN;
      prev_ba    = bomb_active;
      prev_blast = blast;
      prev_blink = fuse_blink;
      prev_sof   = startOfFrame;
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int chain_at;
      resetN = 1'b1;
      startOfFrame = 1'b0;
      place_bomb = 1'b0;
      chain_hit = 1'b0;
      playerX = '0;
      playerY = '0;
      random_num = '0;
      repeat (3) step();
      resetN = 1'b0;
      step();

      // natural fuse from a known position
      run_episode(100, 70, 3, 0, -1);

      // every random_num value, mostly chain-triggered
      for (int i = 0; i < 8; i++) begin
         if (i == 5)      chain_at = FUSE;
         else if (i == 2) chain_at = 10;
         else             chain_at = $urandom_range(1, 20);
         run_episode($urandom_range(0, 2047), $urandom_range(0, 2047), i, chain_at, -1);
      end

      // reset 12 frames into BLAST, then a normal bomb afterwards
      run_episode($urandom_range(0, 2047), $urandom_range(0, 2047), 6, 3, 12);
      run_episode($urandom_range(0, 2047), $urandom_range(0, 2047), 5, 7, -1);

      repeat (20) step();
      check("scoreboard_empty", exp_q.size(), 0);
      check("episodes_completed", eps_done, 10);
      check("spurious_done", spurious_done, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/bomb_blast_sequencer.md
Name: bomb_blast_sequencer

Overview:
- Writer side of the blast-pattern interface: owns one bomb from placement to explosion and drives the blast/blast_num pair that the blast-bitmap drawer samples.
- Counts the fuse in frames, picks a blast pattern (0 regular cross, 1 vertical, 2 horizontal) from the random source, and holds blast for a fixed frame count.
- Exports the tile-aligned bomb position, a fuse-blink flag and a done pulse to the bomb-drawing and collision logic.

Parameters:
- FUSE_FRAMES, 180, frames from placement to detonation (3 s at 60 Hz).
- BLAST_FRAMES, 30, frames blast stays high.
- COOLDOWN_FRAMES, 15, frames after blast before a new bomb is accepted.
- FAST_BLINK_FRAMES, 32, final fuse frames that use fast blink.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, synchronous, active-high (codebase port name kept).
- startOfFrame  in  1  one-cycle pulse per video frame.
- place_bomb  in  1  one-cycle request to place a bomb.
- playerX  in  11  player top-left x, in pixels.
- playerY  in  11  player top-left y, in pixels.
- random_num  in  3  free-running random value.
- chain_hit  in  1  one-cycle pulse: another blast covers this bomb's tile.
- bomb_active  out  1  bomb placed and fuse running (ARMED or PRIME).
- bombX  out  11  latched bomb x, tile-aligned.
- bombY  out  11  latched bomb y, tile-aligned.
- fuse_blink  out  1  blink flag for bomb sprite.
- blast  out  1  explosion in progress.
- blast_num  out  3  pattern index, 0..2.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at the BLAST->COOLDOWN transition.

Behaviour:
- Reset (resetN=1 at a clk edge):
  - State IDLE; all counters 0.
  - All outputs 0, including bombX/bombY and blast_num.
- Frame counter: 8-bit frame_cnt, increments only on startOfFrame, and clears on every state entry.
- IDLE:
  - place_bomb=1 captures bombX = {playerX[10:5], 5'b0} and bombY = {playerY[10:5], 5'b0}.
  - Goes to ARMED on the next edge.
  - chain_hit is ignored in IDLE.
- ARMED:
  - bomb_active=1.
  - When frame_cnt == FUSE_FRAMES-1 and startOfFrame=1, go to PRIME.
  - chain_hit=1 goes to PRIME on the next edge regardless of frame_cnt. If it coincides with the fuse expiry, the result is a single PRIME, not two.
  - place_bomb is ignored in every state except IDLE.
- PRIME (exactly one cycle):
  - bomb_active=1, blast=0.
  - blast_num is registered from mod3(random_num): 0,1,2 map to themselves; 3,4,5 map to 0,1,2; 6,7 map to 0,1.
  - The drawer latches blast_num while blast=0, so blast_num must be valid for at least one cycle before blast rises.
- BLAST:
  - blast=1, bomb_active=0.
  - blast_num is held constant for the whole state.
  - Exit when frame_cnt == BLAST_FRAMES-1 and startOfFrame=1. On that edge go to COOLDOWN and pulse done for one cycle.
  - chain_hit is ignored.
- COOLDOWN:
  - blast=0; blast_num keeps its last value.
  - Go to IDLE after COOLDOWN_FRAMES frames.
  - A place_bomb that arrives during COOLDOWN is dropped, not queued.
- fuse_blink:
  - Valid in ARMED only: frame_cnt[3] normally, frame_cnt[1] once remaining frames < FAST_BLINK_FRAMES.
  - 0 in all other states.
- busy = (state != IDLE).
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency: place_bomb to bomb_active is 1 clk. PRIME entry to blast=1 is 1 clk.
- Reset in any state, including mid-BLAST: immediate return to IDLE with blast=0 and no done pulse.
- Counter widths: all *_FRAMES values must be ≤ 255. An out-of-range value is an elaboration-time assertion.

Decomposition:
- Shared package bomb_pkg holds:
  - state enum {IDLE, ARMED, PRIME, BLAST, COOLDOWN};
  - BLAST_REGULAR=0, BLAST_VERTICAL=1, BLAST_HORIZONTAL=2, NUM_BLAST_PATTERNS=3;
  - TILE_BITS=5;
  - function mod3_3b.
- One natural sub-module: frame_tick_counter, a clearable 8-bit counter advanced by startOfFrame with a terminal-count compare.

Test Plan:
- Basic fuse: reset, place_bomb with playerX=100, playerY=70 → bombX=96, bombY=64, bomb_active the next clk. Blast rises after exactly 180 startOfFrame pulses plus 1 PRIME clk, stays high 30 frames, then done pulses once.
- Pattern mapping: random_num=0..7 in separate runs → blast_num sequence 0,1,2,0,1,2,0,1. Random_num changed mid-BLAST → blast_num unchanged.
- Chain: chain_hit after 10 frames of ARMED → PRIME on the next edge, blast=1 one clk later. chain_hit coincident with fuse expiry → a single blast episode.
- Ignored requests: place_bomb during ARMED, BLAST and COOLDOWN → bombX/bombY unchanged, no second bomb. place_bomb one clk after returning to IDLE → accepted.
- Blink: fuse_blink period 16 frames until 32 frames remain, then period 4. fuse_blink=0 in BLAST.
- Reset mid-BLAST at frame 12 → next clk: blast=0, busy=0, done=0, all outputs 0.
